// File: rtl/sync_aligner.sv
// sync_aligner: re-synchronises pixels read from the ColorTransform FIFO with
// results returned by the Homography engine.
//
// Every pixel presented on q/rdreq is forwarded one cycle later as a
// coordinate query (query_x/query_y/start). The pixel is also kept in an
// in-order pending queue of DEPTH entries. Each ready beat from Homography
// pops the oldest pending pixel. That pixel is presented next cycle, together
// with the returned CCD colour, as one aligned beat (val, sync_*, dvi_*, ccd_*).
//
// Ports
//   clk_25, rst_n        pixel clock, asynchronous active-low reset
//   q, rdreq             FIFO pixel {x, y, r8, g8, b8} and its valid (push)
//   return_x/_y, r/g/b   Homography echo coordinates and CCD colour
//   ready                Homography result valid (pop)
//   flush                synchronous clear of the pending queue
//   err_clr              synchronous clear of sticky flags and mismatch count
//   query_x/_y, start    registered coordinate query
//   val, sync_x/_y       aligned beat valid, coordinates of popped pixel
//   dvi_r/_g/_b          FIFO colour of popped pixel (truncated to R/G/B_W)
//   ccd_r/_g/_b          registered Homography colour
//   level                queue occupancy 0..DEPTH
//   overflow, underflow  sticky push-on-full / pop-on-empty flags
//   mismatch, mismatch_cnt  sticky coordinate mismatch flag, saturating count

module sync_aligner #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned R_W     = 5,
    parameter int unsigned G_W     = 6,
    parameter int unsigned B_W     = 5,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned MCNT_W  = 8
) (
    input  logic                   clk_25,
    input  logic                   rst_n,
    input  logic [2*COORD_W+23:0]  q,
    input  logic                   rdreq,
    input  logic [COORD_W-1:0]     return_x,
    input  logic [COORD_W-1:0]     return_y,
    input  logic [R_W-1:0]         r,
    input  logic [G_W-1:0]         g,
    input  logic [B_W-1:0]         b,
    input  logic                   ready,
    input  logic                   flush,
    input  logic                   err_clr,
    output logic [COORD_W-1:0]     query_x,
    output logic [COORD_W-1:0]     query_y,
    output logic                   start,
    output logic                   val,
    output logic [COORD_W-1:0]     sync_x,
    output logic [COORD_W-1:0]     sync_y,
    output logic [R_W-1:0]         dvi_r,
    output logic [G_W-1:0]         dvi_g,
    output logic [B_W-1:0]         dvi_b,
    output logic [R_W-1:0]         ccd_r,
    output logic [G_W-1:0]         ccd_g,
    output logic [B_W-1:0]         ccd_b,
    output logic [ADDR_W:0]        level,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   mismatch,
    output logic [MCNT_W-1:0]      mismatch_cnt
);

    localparam int unsigned Q_W   = 2*COORD_W + 24;
    localparam int unsigned C_W   = R_W + G_W + B_W;
    localparam int unsigned E_W   = 2*COORD_W + C_W;
    localparam int unsigned LVL_W = ADDR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Input field split of the FIFO word {x, y, r8, g8, b8}
    logic [COORD_W-1:0] w_q_x;
    logic [COORD_W-1:0] w_q_y;
    logic [7:0]         w_q_r8;
    logic [7:0]         w_q_g8;
    logic [7:0]         w_q_b8;
    logic [E_W-1:0]     w_wr_entry;

    assign w_q_x  = q[Q_W-1 -: COORD_W];
    assign w_q_y  = q[Q_W-COORD_W-1 -: COORD_W];
    assign w_q_r8 = q[23:16];
    assign w_q_g8 = q[15:8];
    assign w_q_b8 = q[7:0];

    // Stored colour keeps the MSBs of each 8-bit channel
    assign w_wr_entry = {w_q_x, w_q_y, w_q_r8[7 -: R_W], w_q_g8[7 -: G_W], w_q_b8[7 -: B_W]};

    // Pending queue storage and pointers
    logic [E_W-1:0]    r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]  r_level;

    // Head entry decode
    logic [E_W-1:0]     w_head;
    logic [COORD_W-1:0] w_head_x;
    logic [COORD_W-1:0] w_head_y;
    logic [R_W-1:0]     w_head_r;
    logic [G_W-1:0]     w_head_g;
    logic [B_W-1:0]     w_head_b;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_head_x = w_head[E_W-1 -: COORD_W];
    assign w_head_y = w_head[E_W-COORD_W-1 -: COORD_W];
    assign w_head_r = w_head[C_W-1 -: R_W];
    assign w_head_g = w_head[G_W+B_W-1 -: G_W];
    assign w_head_b = w_head[B_W-1:0];

    // Output and status registers
    logic [COORD_W-1:0] r_query_x;
    logic [COORD_W-1:0] r_query_y;
    logic               r_start;
    logic               r_val;
    logic [COORD_W-1:0] r_sync_x;
    logic [COORD_W-1:0] r_sync_y;
    logic [R_W-1:0]     r_dvi_r;
    logic [G_W-1:0]     r_dvi_g;
    logic [B_W-1:0]     r_dvi_b;
    logic [R_W-1:0]     r_ccd_r;
    logic [G_W-1:0]     r_ccd_g;
    logic [B_W-1:0]     r_ccd_b;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_mismatch;
    logic [MCNT_W-1:0]  r_mcnt;

    // Next-state signals
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_new_of;
    logic              w_new_uf;
    logic              w_new_mis;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic              w_of_nxt;
    logic              w_uf_nxt;
    logic              w_mis_nxt;
    logic [MCNT_W-1:0] w_mcnt_nxt;

    // Queue control, error detection and sticky-flag next state
    always_comb begin
        w_empty      = (r_level == '0);
        w_full       = (r_level == FULL_LVL);
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_new_of     = 1'b0;
        w_new_uf     = 1'b0;
        w_new_mis    = 1'b0;
        w_level_nxt  = r_level;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_of_nxt     = r_overflow;
        w_uf_nxt     = r_underflow;
        w_mis_nxt    = r_mismatch;
        w_mcnt_nxt   = r_mcnt;

        if (flush) begin
            // Flush wins over any same-cycle queue traffic
            w_level_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            w_pop     = ready && !w_empty;
            // Full check uses post-pop occupancy, so push+pop at full succeeds
            w_push    = rdreq && (!w_full || w_pop);
            w_new_of  = rdreq && w_full && !w_pop;
            w_new_uf  = ready && w_empty;
            w_new_mis = w_pop && ((w_head_x != return_x) || (w_head_y != return_y));

            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + LVL_W'(1);
                2'b01:   w_level_nxt = r_level - LVL_W'(1);
                default: w_level_nxt = r_level;
            endcase
        end

        // A new error in the clearing cycle is still recorded
        if (err_clr) begin
            w_of_nxt   = w_new_of;
            w_uf_nxt   = w_new_uf;
            w_mis_nxt  = w_new_mis;
            w_mcnt_nxt = MCNT_W'(w_new_mis);
        end else begin
            w_of_nxt  = r_overflow  || w_new_of;
            w_uf_nxt  = r_underflow || w_new_uf;
            w_mis_nxt = r_mismatch  || w_new_mis;
            if (w_new_mis && !(&r_mcnt)) begin
                w_mcnt_nxt = r_mcnt + MCNT_W'(1);
            end
        end
    end

    // Queue storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_25) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Pointers, level and sticky status
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_mismatch  <= 1'b0;
            r_mcnt      <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            r_overflow  <= w_of_nxt;
            r_underflow <= w_uf_nxt;
            r_mismatch  <= w_mis_nxt;
            r_mcnt      <= w_mcnt_nxt;
        end
    end

    // Query path: one-cycle registered copy of the pixel coordinates
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_start   <= 1'b0;
            r_query_x <= '0;
            r_query_y <= '0;
        end else begin
            r_start <= rdreq;
            if (rdreq) begin
                r_query_x <= w_q_x;
                r_query_y <= w_q_y;
            end
        end
    end

    // Aligned output beat: loads on pop, otherwise holds
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_val    <= 1'b0;
            r_sync_x <= '0;
            r_sync_y <= '0;
            r_dvi_r  <= '0;
            r_dvi_g  <= '0;
            r_dvi_b  <= '0;
            r_ccd_r  <= '0;
            r_ccd_g  <= '0;
            r_ccd_b  <= '0;
        end else begin
            r_val <= w_pop;
            if (w_pop) begin
                r_sync_x <= w_head_x;
                r_sync_y <= w_head_y;
                r_dvi_r  <= w_head_r;
                r_dvi_g  <= w_head_g;
                r_dvi_b  <= w_head_b;
                r_ccd_r  <= r;
                r_ccd_g  <= g;
                r_ccd_b  <= b;
            end
        end
    end

    assign query_x      = r_query_x;
    assign query_y      = r_query_y;
    assign start        = r_start;
    assign val          = r_val;
    assign sync_x       = r_sync_x;
    assign sync_y       = r_sync_y;
    assign dvi_r        = r_dvi_r;
    assign dvi_g        = r_dvi_g;
    assign dvi_b        = r_dvi_b;
    assign ccd_r        = r_ccd_r;
    assign ccd_g        = r_ccd_g;
    assign ccd_b        = r_ccd_b;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign mismatch     = r_mismatch;
    assign mismatch_cnt = r_mcnt;

endmodule

// File: tb/tb_sync_aligner.sv
// Self-checking bench for sync_aligner: table vectors for the basic
// push/pop flow, hand sequences for full/empty/saturation/wrap/flush/reset,
// then randomized traffic against a queue-based reference model.

module tb_sync_aligner;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned R_W     = 5;
    localparam int unsigned G_W     = 6;
    localparam int unsigned B_W     = 5;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned MCNT_W  = 8;
    localparam int unsigned MCNT_MAX = (1 << MCNT_W) - 1;

    logic                  clk_25;
    logic                  rst_n;
    logic [2*COORD_W+23:0] q;
    logic                  rdreq;
    logic [COORD_W-1:0]    return_x, return_y;
    logic [R_W-1:0]        r;
    logic [G_W-1:0]        g;
    logic [B_W-1:0]        b;
    logic                  ready, flush, err_clr;
    logic [COORD_W-1:0]    query_x, query_y;
    logic                  start, val;
    logic [COORD_W-1:0]    sync_x, sync_y;
    logic [R_W-1:0]        dvi_r, ccd_r;
    logic [G_W-1:0]        dvi_g, ccd_g;
    logic [B_W-1:0]        dvi_b, ccd_b;
    logic [ADDR_W:0]       level;
    logic                  overflow, underflow, mismatch;
    logic [MCNT_W-1:0]     mismatch_cnt;

    sync_aligner #(
        .COORD_W(COORD_W), .R_W(R_W), .G_W(G_W), .B_W(B_W),
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MCNT_W(MCNT_W)
    ) dut (
        .clk_25(clk_25), .rst_n(rst_n), .q(q), .rdreq(rdreq),
        .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
        .ready(ready), .flush(flush), .err_clr(err_clr),
        .query_x(query_x), .query_y(query_y), .start(start), .val(val),
        .sync_x(sync_x), .sync_y(sync_y),
        .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
        .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
        .level(level), .overflow(overflow), .underflow(underflow),
        .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
    );

    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    int n_checks = 0;
    int n_err    = 0;

    // Stimulus fields (the model reads these, not q)
    int unsigned s_x, s_y, s_r8, s_g8, s_b8;
    int unsigned s_rx, s_ry, s_r, s_g, s_b;

    // Reference model state
    typedef struct {
        int unsigned x, y, r, g, b;
    } ent_t;
    ent_t mq[$];
    int unsigned m_start, m_qx, m_qy, m_val, m_sx, m_sy;
    int unsigned m_dr, m_dg, m_db, m_cr, m_cg, m_cb;
    int unsigned m_of, m_uf, m_mis, m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_start = 0; m_qx = 0; m_qy = 0; m_val = 0; m_sx = 0; m_sy = 0;
        m_dr = 0; m_dg = 0; m_db = 0; m_cr = 0; m_cg = 0; m_cb = 0;
        m_of = 0; m_uf = 0; m_mis = 0; m_cnt = 0;
    endtask

    // One clock of the behavioural rules, evaluated on the current inputs
    task automatic model_step();
        bit new_of, new_uf, new_mis;
        ent_t e;
        new_of = 0; new_uf = 0; new_mis = 0;
        m_start = rdreq;
        if (rdreq) begin
            m_qx = s_x;
            m_qy = s_y;
        end
        m_val = 0;
        if (flush) begin
            mq.delete();
        end else begin
            // Pop is decided on the queue as it stood before this cycle's push
            if (ready) begin
                if (mq.size() == 0) begin
                    new_uf = 1;
                end else begin
                    e = mq.pop_front();
                    m_val = 1;
                    m_sx = e.x; m_sy = e.y;
                    m_dr = e.r; m_dg = e.g; m_db = e.b;
                    m_cr = s_r; m_cg = s_g; m_cb = s_b;
                    new_mis = (e.x != s_rx) || (e.y != s_ry);
                end
            end
            if (rdreq) begin
                if (mq.size() < DEPTH) begin
                    e.x = s_x; e.y = s_y;
                    e.r = s_r8 >> (8 - R_W);
                    e.g = s_g8 >> (8 - G_W);
                    e.b = s_b8 >> (8 - B_W);
                    mq.push_back(e);
                end else begin
                    new_of = 1;
                end
            end
        end
        if (err_clr) begin
            m_of = new_of; m_uf = new_uf; m_mis = new_mis; m_cnt = new_mis;
        end else begin
            m_of  = m_of  | new_of;
            m_uf  = m_uf  | new_uf;
            m_mis = m_mis | new_mis;
            if (new_mis && m_cnt < MCNT_MAX) m_cnt++;
        end
    endtask

    task automatic check_all();
        check("start", start, m_start);
        check("query_x", query_x, m_qx);
        check("query_y", query_y, m_qy);
        check("val", val, m_val);
        check("sync_x", sync_x, m_sx);
        check("sync_y", sync_y, m_sy);
        check("dvi_r", dvi_r, m_dr);
        check("dvi_g", dvi_g, m_dg);
        check("dvi_b", dvi_b, m_db);
        check("ccd_r", ccd_r, m_cr);
        check("ccd_g", ccd_g, m_cg);
        check("ccd_b", ccd_b, m_cb);
        check("level", level, mq.size());
        check("overflow", overflow, m_of);
        check("underflow", underflow, m_uf);
        check("mismatch", mismatch, m_mis);
        check("mismatch_cnt", mismatch_cnt, m_cnt);
    endtask

    // Advance one clock; outputs compared 1 time unit after the edge
    task automatic tick();
        model_step();
        @(posedge clk_25);
        #1;
        check_all();
    endtask

    task automatic idle();
        rdreq = 0; ready = 0; flush = 0; err_clr = 0;
        s_x = 0; s_y = 0; s_r8 = 0; s_g8 = 0; s_b8 = 0;
        s_rx = 0; s_ry = 0; s_r = 0; s_g = 0; s_b = 0;
        q = '0; return_x = '0; return_y = '0; r = '0; g = '0; b = '0;
    endtask

    task automatic set_push(input int unsigned x, input int unsigned y,
                            input int unsigned r8, input int unsigned g8, input int unsigned b8);
        rdreq = 1;
        s_x = x; s_y = y; s_r8 = r8; s_g8 = g8; s_b8 = b8;
        q = {COORD_W'(x), COORD_W'(y), 8'(r8), 8'(g8), 8'(b8)};
    endtask

    task automatic set_pop(input int unsigned rx, input int unsigned ry,
                           input int unsigned rr, input int unsigned gg, input int unsigned bb);
        ready = 1;
        s_rx = rx; s_ry = ry; s_r = rr; s_g = gg; s_b = bb;
        return_x = COORD_W'(rx); return_y = COORD_W'(ry);
        r = R_W'(rr); g = G_W'(gg); b = B_W'(bb);
    endtask

    typedef struct {
        bit          rd;
        int unsigned x;
        bit          rdy;
        int unsigned rx;
        bit          e_start;
        int unsigned e_qx;
        bit          e_val;
        int unsigned e_sx;
        int unsigned e_level;
        bit          e_mis;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int unsigned p;
        idle();
        model_reset();
        rst_n = 0;

        // Table: three pushes then three matching pops (y=10, ff/80/07 -> 31/32/0)
        tbl[0] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[1] = '{1, 2, 0, 0, 1, 2, 0, 0, 2, 0};
        tbl[2] = '{1, 3, 0, 0, 1, 3, 0, 0, 3, 0};
        tbl[3] = '{0, 0, 1, 1, 0, 3, 1, 1, 2, 0};
        tbl[4] = '{0, 0, 1, 2, 0, 3, 1, 2, 1, 0};
        tbl[5] = '{0, 0, 1, 3, 0, 3, 1, 3, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 3, 0, 3, 0, 0};

        #7;
        check_all();
        check("rst_level", level, 0);
        @(negedge clk_25);
        rst_n = 1;
        @(posedge clk_25);
        #1;

        for (int i = 0; i < 7; i++) begin
            idle();
            if (tbl[i].rd)  set_push(tbl[i].x, 10, 8'hFF, 8'h80, 8'h07);
            if (tbl[i].rdy) set_pop(tbl[i].rx, 10, 5, 6, 7);
            tick();
            check("tbl_start", start, tbl[i].e_start);
            check("tbl_query_x", query_x, tbl[i].e_qx);
            check("tbl_val", val, tbl[i].e_val);
            check("tbl_sync_x", sync_x, tbl[i].e_sx);
            check("tbl_level", level, tbl[i].e_level);
            check("tbl_mismatch", mismatch, tbl[i].e_mis);
            if (tbl[i].e_val) begin
                check("tbl_dvi", {dvi_r, dvi_g, dvi_b}, {5'd31, 6'd32, 5'd0});
                check("tbl_ccd", {ccd_r, ccd_g, ccd_b}, {5'd5, 6'd6, 5'd7});
            end
        end

        // Fill to DEPTH, ninth push dropped
        for (int i = 0; i < 8; i++) begin
            idle(); set_push(i, 0, 8'h10 * i, 8'h20, 8'h30); tick();
        end
        idle(); set_push(99, 0, 0, 0, 0); tick();
        check("full_level", level, DEPTH);
        check("full_overflow", overflow, 1);
        check("full_start", start, 1);
        for (int i = 0; i < 8; i++) begin
            idle(); set_pop(i, 0, 1, 2, 3); tick();
            check("full_order_x", sync_x, i);
        end
        check("drain_level", level, 0);
        check("drain_mismatch", mismatch, 0);

        // Pop on empty, then clear
        idle(); set_pop(7, 0, 9, 9, 9); tick();
        check("empty_val", val, 0);
        check("empty_underflow", underflow, 1);
        check("empty_hold_x", sync_x, 7);
        idle(); err_clr = 1; tick();
        check("clr_flags", {overflow, underflow, mismatch}, 0);

        // Counter saturation: 300 mismatching pops with level held at 1
        idle(); set_push(500, 1, 0, 0, 0); tick();
        for (int i = 0; i < 300; i++) begin
            idle(); set_push(i, 1, 0, 0, 0); set_pop(1023, 1, 0, 0, 0); tick();
        end
        check("sat_cnt", mismatch_cnt, MCNT_MAX);
        check("sat_flag", mismatch, 1);
        check("sat_level", level, 1);
        // Mismatch coinciding with err_clr is recorded as count 1
        idle(); err_clr = 1; set_pop(1023, 1, 0, 0, 0); tick();
        check("clr_new_cnt", mismatch_cnt, 1);
        check("clr_new_flag", mismatch, 1);
        idle(); err_clr = 1; tick();
        check("clr_cnt", mismatch_cnt, 0);

        // Concurrent push/pop at level 4 across pointer wrap, then flush
        for (int i = 0; i < 4; i++) begin
            idle(); set_push(100 + i, 2, 8'hA0, 8'hB0, 8'hC0); tick();
        end
        for (int i = 0; i < 20; i++) begin
            idle(); set_push(104 + i, 2, 8'hA0, 8'hB0, 8'hC0); set_pop(100 + i, 2, 4, 4, 4); tick();
            check("wrap_level", level, 4);
            check("wrap_x", sync_x, 100 + i);
        end
        check("wrap_mismatch", mismatch, 0);
        idle(); flush = 1; tick();
        check("flush_level", level, 0);
        check("flush_keep_x", sync_x, 119);
        idle(); set_pop(0, 0, 0, 0, 0); tick();
        check("flush_underflow", underflow, 1);
        check("flush_val", val, 0);

        // Full with simultaneous push and pop stays full
        for (int i = 0; i < 8; i++) begin
            idle(); set_push(200 + i, 3, 0, 0, 0); tick();
        end
        idle(); err_clr = 1; set_push(208, 3, 0, 0, 0); set_pop(200, 3, 0, 0, 0); tick();
        check("fullpp_level", level, DEPTH);
        check("fullpp_overflow", overflow, 0);
        check("fullpp_x", sync_x, 200);

        // Asynchronous reset mid-operation
        idle(); set_push(300, 4, 0, 0, 0); tick();
        rst_n = 0;
        #2;
        check("arst_level", level, 0);
        check("arst_start", start, 0);
        check("arst_sync_x", sync_x, 0);
        check("arst_flags", {overflow, underflow, mismatch}, 0);
        model_reset();
        idle();
        #5;
        rst_n = 1;
        @(posedge clk_25);
        #1;
        check_all();

        // Randomized traffic with varying fill pressure
        for (int ph = 0; ph < 6; ph++) begin
            p = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 50 : 80);
            for (int i = 0; i < 500; i++) begin
                idle();
                if ($urandom_range(0, 99) < p)
                    set_push($urandom_range(0, 1023), $urandom_range(0, 1023),
                             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                if ($urandom_range(0, 99) < 50) begin
                    if (mq.size() > 0 && $urandom_range(0, 7) != 0)
                        set_pop(mq[0].x, mq[0].y, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31));
                    else
                        set_pop($urandom_range(0, 1023), $urandom_range(0, 1023),
                                $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31));
                end
                flush   = ($urandom_range(0, 59) == 0);
                err_clr = ($urandom_range(0, 29) == 0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
